// File: rtl/instr_mem_fetch.sv
// Instruction memory with a one-cycle fetch handshake and a 2-entry response FIFO.
// Define IMEM_WRITE_EN to add a word-write port for program load.
module instr_mem_fetch #(
   parameter int    DEPTH     = 64,
   parameter int    ADDR_W    = $clog2(DEPTH),
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
`ifdef IMEM_WRITE_EN
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
`endif
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [1:0]  rsp_fault,
   output logic [31:0] rsp_addr
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [1:0]  fault;
      logic [31:0] addr;
   } entry_t;

   logic [31:0] mem_q [DEPTH] = '{default: NOP};

   logic [1:0]        occ_q, occ_d;
   entry_t            head_q, head_d;
   entry_t            tail_q, tail_d;
   logic [ADDR_W-1:0] rd_idx;
   entry_t            new_entry;
   logic              accept;
   logic              pop;

   // Out-of-range is judged on every upper address bit so the index never wraps.
   assign rd_idx          = req_addr[ADDR_W+1:2];
   assign new_entry.fault = {(req_addr[31:ADDR_W+2] != '0), (req_addr[1:0] != 2'b00)};
   assign new_entry.instr = (new_entry.fault != 2'b00) ? NOP : mem_q[rd_idx];
   assign new_entry.addr  = req_addr;

   assign req_ready = rst_n & ~flush & (occ_q != 2'd2);
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (occ_q != 2'd0);
   assign pop       = rsp_valid & rsp_ready & ~flush;

   assign rsp_instr = head_q.instr;
   assign rsp_fault = head_q.fault;
   assign rsp_addr  = head_q.addr;

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         case ({accept, pop})
            2'b10: begin
               occ_d = occ_q + 2'd1;
               if (occ_q == 2'd0) head_d = new_entry;
               else               tail_d = new_entry;
            end
            2'b01: begin
               occ_d = occ_q - 2'd1;
               if (occ_q == 2'd2) head_d = tail_q;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  head_d = new_entry;
               end else begin
                  head_d = tail_q;
                  tail_d = new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         head_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
      end
   end

   // Second slot is only ever observed after being written, so it needs no reset.
   always_ff @(posedge clk) begin
      tail_q <= tail_d;
   end

`ifdef IMEM_WRITE_EN
   // Non-blocking write: a same-edge fetch of this word captures the old contents.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr[31:ADDR_W+2] == '0)) begin
         mem_q[wr_addr[ADDR_W+1:2]] <= wr_data;
      end
   end
`endif

endmodule
